// File: rtl/bcd_display_conv.sv
// -----------------------------------------------------------------------------
// bcd_display_conv
//
// Converts a W-bit value into N_DIG display digit codes for a segment-style
// display. The value is interpreted as unsigned, signed two's-complement,
// raw binary bits or an error indication, selected by mode. Decimal
// conversion uses a serial shift-add-3 (double-dabble) loop, one bit per
// clock, so the latency is W+2 clocks from accepted start to done for every
// mode.
//
// Digit codes: 0-9 numerals, 10 = minus / error dash, 11 = blank.
//
// Build option:
//   BCD_LZB_EN  defined   -> leading zeros in decimal modes are blanked (11)
//                            and the minus sign sits next to the most
//                            significant displayed digit.
//               undefined -> leading zeros are shown as 0 and the minus
//                            sign occupies the leftmost digit.
//
// Parameters:
//   W      binary input width (4..32)
//   N_DIG  number of display digits (2..8)
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   start   in   conversion request, only accepted while idle and not busy
//   mode    in   0 unsigned, 1 signed, 2 binary, 3 error; sampled with start
//   val     in   value to convert; sampled with start
//   busy    out  high while a conversion is in progress
//   done    out  one-cycle pulse when digits update
//   digits  out  digit codes, bits [4*N_DIG-1 -: 4] are the leftmost digit
// -----------------------------------------------------------------------------
module bcd_display_conv #(
   parameter int W     = 12,
   parameter int N_DIG = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [W-1:0]       val,
   output logic               busy,
   output logic               done,
   output logic [4*N_DIG-1:0] digits
);

   // Number of BCD digits needed to hold 2^W - 1.
   function automatic int bcd_digits_for(input int width);
      logic [63:0] v;
      int          n;
      v = (64'd1 << width) - 64'd1;
      n = 1;
      for (int i = 0; i < 20; i++) begin
         if (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
         end
      end
      return n;
   endfunction

   localparam int NB    = bcd_digits_for(W);
   localparam int CNT_W = $clog2(W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_FMT,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [W-1:0]        bin_q, bin_d;
   logic [W-1:0]        raw_q, raw_d;
   logic [4*NB-1:0]     bcd_q, bcd_d;
   logic [1:0]          mode_q, mode_d;
   logic                neg_q, neg_d;
   logic [4*N_DIG-1:0]  fmt_q, fmt_d;
   logic [4*N_DIG-1:0]  digits_q, digits_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;

   logic [W-1:0]        val_mag;
   logic [4*NB-1:0]     bcd_adj;

   // Magnitude of the incoming value; only signed mode folds negatives.
   assign val_mag = (mode == 2'd1 && val[W-1]) ? (~val + 1'b1) : val;

   // Add-3 correction on every BCD digit that would exceed 9 after doubling.
   for (genvar gi = 0; gi < NB; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                  (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];
   end

   // Build the display codes from the finished BCD magnitude.
   function automatic logic [4*N_DIG-1:0] format_codes(
      input logic [1:0]      m,
      input logic            neg,
      input logic [4*NB-1:0] bcd,
      input logic [W-1:0]    raw
   );
      logic [4*(NB+N_DIG)-1:0] bcd_ext;
      logic [W+N_DIG-1:0]      raw_ext;
      logic [4*N_DIG-1:0]      codes;
      logic                    ovf;
      int                      lim;
`ifdef BCD_LZB_EN
      int                      msd;
`endif
      // Zero-extended copies let the loops index past the real widths.
      bcd_ext             = '0;
      bcd_ext[4*NB-1:0]   = bcd;
      raw_ext             = '0;
      raw_ext[W-1:0]      = raw;
      codes               = '0;
      ovf                 = 1'b0;
      // A negative number gives up one digit position to the minus sign.
      lim                 = neg ? (N_DIG - 1) : N_DIG;
      for (int i = 0; i < NB + N_DIG; i++) begin
         if (i >= lim && bcd_ext[4*i +: 4] != 4'd0) begin
            ovf = 1'b1;
         end
      end
`ifdef BCD_LZB_EN
      msd = 0;
      for (int i = 0; i < N_DIG; i++) begin
         if (bcd_ext[4*i +: 4] != 4'd0) begin
            msd = i;
         end
      end
`endif
      case (m)
         2'd2: begin
            for (int i = 0; i < N_DIG; i++) begin
               codes[4*i +: 4] = {3'b000, raw_ext[i]};
            end
         end
         2'd3: begin
            codes = {N_DIG{4'd10}};
         end
         default: begin
            if (ovf) begin
               codes = {N_DIG{4'd10}};
            end else begin
`ifdef BCD_LZB_EN
               // Digit 0 is never above msd, so it always shows a numeral.
               for (int i = 0; i < N_DIG; i++) begin
                  if (i > msd) begin
                     codes[4*i +: 4] = (neg && i == msd + 1) ? 4'd10 : 4'd11;
                  end else begin
                     codes[4*i +: 4] = bcd_ext[4*i +: 4];
                  end
               end
`else
               for (int i = 0; i < N_DIG; i++) begin
                  codes[4*i +: 4] = bcd_ext[4*i +: 4];
               end
               // No overflow guarantees the leftmost digit is zero here.
               if (neg) begin
                  codes[4*N_DIG-1 -: 4] = 4'd10;
               end
`endif
            end
         end
      endcase
      return codes;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bin_q    <= '0;
         raw_q    <= '0;
         bcd_q    <= '0;
         mode_q   <= 2'd0;
         neg_q    <= 1'b0;
         fmt_q    <= '0;
         digits_q <= {N_DIG{4'd11}};
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bin_q    <= bin_d;
         raw_q    <= raw_d;
         bcd_q    <= bcd_d;
         mode_q   <= mode_d;
         neg_q    <= neg_d;
         fmt_q    <= fmt_d;
         digits_q <= digits_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bin_d    = bin_q;
      raw_d    = raw_q;
      bcd_d    = bcd_q;
      mode_d   = mode_q;
      neg_d    = neg_q;
      fmt_d    = fmt_q;
      digits_d = digits_q;
      done_d   = 1'b0;
      busy_d   = busy_q;
      case (state_q)
         S_IDLE: begin
            // busy stays high through the done cycle, so a start seen
            // during the pulse is ignored and taken one clock later.
            if (done_q) begin
               busy_d = 1'b0;
            end
            if (start && !busy_q) begin
               mode_d  = mode;
               neg_d   = (mode == 2'd1) && val[W-1];
               bin_d   = val_mag;
               raw_d   = val;
               bcd_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_CONV;
            end
         end
         S_CONV: begin
            // Runs in every mode so the latency never depends on mode.
            bcd_d   = (4*NB)'({bcd_adj, bin_q[W-1]});
            bin_d   = {bin_q[W-2:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               state_d = S_FMT;
            end
         end
         S_FMT: begin
            fmt_d   = format_codes(mode_q, neg_q, bcd_q, raw_q);
            state_d = S_DONE;
         end
         S_DONE: begin
            digits_d = fmt_q;
            done_d   = 1'b1;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign digits = digits_q;

endmodule
